// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
//   Bundle between the execute stage / hazard unit and the RV32M multiply/divide
//   unit.
//
//   master (EX stage side) drives:
//     start        valid M-op in EX this cycle
//     flush        abort any in-flight op (branch/jump flush)
//     funct3       RV32M opcode selector
//     srcA, srcB   forwarded rs1 / rs2 operands
//   slave (muldiv_unit) drives:
//     busy         op iterating
//     done         one-cycle result-valid pulse
//     result       registered result, held until the next accepted op completes
//     muldiv_stall combinational stall request to the hazard unit
// -----------------------------------------------------------------------------
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            muldiv_stall;

  modport master (
    output start, flush, funct3, srcA, srcB,
    input  busy, done, result, muldiv_stall
  );

  modport slave (
    input  start, flush, funct3, srcA, srcB,
    output busy, done, result, muldiv_stall
  );
endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Execute-stage RV32M unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//   Divide is a restoring divider on operand magnitudes, one quotient bit per
//   cycle for XLEN cycles. Multiply is shift-add on magnitudes for XLEN cycles,
//   followed by a sign fix of the full 2*XLEN product.
//
//   Build option:
//     MULDIV_FAST_MUL_EN  when defined, MUL* ops finish in one cycle
//                         (IDLE -> DONE) using a full 2*XLEN multiplier.
//                         Divide latency is the same either way.
//
//   Ports:
//     clk    in  rising-edge clock
//     reset  in  synchronous, active-high; aborts any op without a done pulse
//     bus    muldiv_unit_if.slave (start/flush/funct3/srcA/srcB in,
//            busy/done/result/muldiv_stall out)
//
//   Timing (start sampled at edge T):
//     iterative op : busy seen at edges T+1..T+XLEN, done seen at T+XLEN+1
//     special/fast : done seen at T+1, busy never set
//   Divide-by-zero and signed overflow (MIN / -1) are resolved in one cycle.
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // control
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  // datapath (no reset: only meaningful while an op is in flight)
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_opd;     // multiplicand magnitude, or divisor magnitude
  logic [XLEN-1:0] r_hi;      // product high half, or partial remainder
  logic [XLEN-1:0] r_lo;      // multiplier/product low half, or dividend/quotient
  logic            r_neg_q;   // operand signs differ (product / quotient sign)
  logic            r_neg_r;   // dividend negative (remainder sign)

  // ---------------------------------------------------------------------------
  // Finishing functions: sign fix and half selection
  // ---------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] mul_finish(input logic [2:0]        f,
                                                 input logic [2*XLEN-1:0] mag,
                                                 input logic              neg);
    logic [2*XLEN-1:0] p;
    p = neg ? (~mag + 1'b1) : mag;
    return (f[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] div_finish(input logic [2:0]      f,
                                                 input logic [XLEN-1:0] q,
                                                 input logic [XLEN-1:0] r,
                                                 input logic            neg_q,
                                                 input logic            neg_r);
    logic [XLEN-1:0] res;
    if (f[1]) res = neg_r ? (~r + 1'b1) : r;
    else      res = neg_q ? (~q + 1'b1) : q;
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Operand decode (acts on the live inputs, used only when an op is accepted)
  // ---------------------------------------------------------------------------
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_fast;
  logic [XLEN-1:0] w_fast_res;
  logic            w_accept;

  assign w_is_div   = bus.funct3[2];
  // DIV/REM are signed on both operands; MULH signed x signed; MULHSU signed x unsigned.
  assign w_a_signed = w_is_div ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01 || bus.funct3[1:0] == 2'b10);
  assign w_b_signed = w_is_div ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01);
  assign w_a_neg    = w_a_signed & bus.srcA[XLEN-1];
  assign w_b_neg    = w_b_signed & bus.srcB[XLEN-1];
  assign w_a_mag    = w_a_neg ? (~bus.srcA + 1'b1) : bus.srcA;
  assign w_b_mag    = w_b_neg ? (~bus.srcB + 1'b1) : bus.srcB;

  assign w_div_zero = w_is_div & (bus.srcB == '0);
  assign w_div_ovf  = w_is_div & ~bus.funct3[0] & (bus.srcA == INT_MIN) & (bus.srcB == '1);
  assign w_special  = w_div_zero | w_div_ovf;

  // funct3[1] distinguishes REM*/DIV*. Zero divisor: quotient all ones, remainder = dividend.
  // Overflow: quotient = INT_MIN (which is srcA), remainder = 0.
  always_comb begin
    w_special_res = '0;
    if (w_div_zero)     w_special_res = bus.funct3[1] ? bus.srcA : '1;
    else if (w_div_ovf) w_special_res = bus.funct3[1] ? '0 : bus.srcA;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] w_fa;
  logic signed [2*XLEN-1:0] w_fb;
  logic signed [2*XLEN-1:0] w_fprod;

  assign w_fa       = $signed({{XLEN{w_a_neg}}, bus.srcA});
  assign w_fb       = $signed({{XLEN{w_b_neg}}, bus.srcB});
  assign w_fprod    = w_fa * w_fb;
  assign w_fast     = ~w_is_div;
  assign w_fast_res = (bus.funct3[1:0] == 2'b00) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`else
  assign w_fast     = 1'b0;
  assign w_fast_res = '0;
`endif

  assign w_accept = (r_state == S_IDLE) & bus.start & ~bus.flush;

  // ---------------------------------------------------------------------------
  // Iteration step
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic [XLEN-1:0] w_hi_nxt;
  logic [XLEN-1:0] w_lo_nxt;

  always_comb begin
    w_sum    = '0;
    w_shift  = '0;
    w_diff   = '0;
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (!r_funct3[2]) begin
      // shift-add: add multiplicand into the high half when the multiplier LSB
      // is set, then shift {carry, hi, lo} right by one
      w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : {(XLEN+1){1'b0}});
      w_hi_nxt = w_sum[XLEN:1];
      w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
    end else begin
      // restoring: bring in next dividend bit, trial-subtract divisor
      w_shift = {r_hi, r_lo[XLEN-1]};
      w_diff  = w_shift - {1'b0, r_opd};
      if (!w_diff[XLEN]) begin
        w_hi_nxt = w_diff[XLEN-1:0];
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_shift[XLEN-1:0];
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_funct3 <= bus.funct3;
      r_opd    <= w_is_div ? w_b_mag : w_a_mag;
      r_hi     <= '0;
      r_lo     <= w_is_div ? w_a_mag : w_b_mag;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
    end else if (r_state == S_CALC) begin
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (bus.flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            if (w_special) begin
              r_result <= w_special_res;
              r_state  <= S_DONE;
              r_done   <= 1'b1;
            end else if (w_fast) begin
              r_result <= w_fast_res;
              r_state  <= S_DONE;
              r_done   <= 1'b1;
            end else begin
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(XLEN-1)) begin
            r_result <= r_funct3[2]
                        ? div_finish(r_funct3, w_lo_nxt, w_hi_nxt, r_neg_q, r_neg_r)
                        : mul_finish(r_funct3, {w_hi_nxt, w_lo_nxt}, r_neg_q);
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.result       = r_result;
  assign bus.muldiv_stall = (bus.start & (r_state == S_IDLE)) | r_busy;

endmodule
